// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache responder.
// master: requester plus memory model; slave: the cache.
interface icache_if;
  logic        icache_req;
  logic [7:0]  icache_index;
  logic [3:0]  icache_offset;
  logic [19:0] icache_tag;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [31:0] icache_rdata;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  modport master (
    output icache_req, icache_index, icache_offset, icache_tag,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  icache_addr_ok, icache_data_ok, icache_rdata, rd_req, rd_addr
  );

  modport slave (
    input  icache_req, icache_index, icache_offset, icache_tag,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output icache_addr_ok, icache_data_ok, icache_rdata, rd_req, rd_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped 256 x 16-byte instruction cache with 4-beat line refill.
// Define ICACHE_PERF_CNT_EN to add the hit/miss performance counters.
module icache_responder (
  input logic     clk,
  input logic     reset,
  icache_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StMiss, StRefill, StResp} state_e;

  state_e      state_q, state_d;
  logic [255:0] valid_q;
  logic [19:0] tag_arr  [256];
  logic [31:0] data_arr [256][4];

  logic [7:0]  idx_q;
  logic [1:0]  word_q;
  logic [19:0] tag_q;
  logic [1:0]  beat_q;
  logic [31:0] resp_word_q;

  logic        hit;
  logic        accept;
  logic        refill_beat;
  logic [31:0] hit_word;

  // Byte-within-word bits are never needed for word fetches.
  logic unused_off_lsb;
  assign unused_off_lsb = ^bus.icache_offset[1:0];

  assign hit         = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);
  assign hit_word    = data_arr[idx_q][word_q];
  assign refill_beat = (state_q == StRefill) && bus.ret_valid;
  assign bus.rd_addr = {tag_q, idx_q, 4'b0000};

  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    bus.icache_data_ok = 1'b0;
    bus.icache_rdata   = '0;
    bus.rd_req         = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept = bus.icache_req && !reset;
        if (accept) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          bus.icache_data_ok = 1'b1;
          bus.icache_rdata   = hit_word;
          accept             = bus.icache_req;
          state_d            = accept ? StLookup : StIdle;
        end else begin
          state_d = StMiss;
        end
      end
      StMiss: begin
        bus.rd_req = 1'b1;
        if (bus.rd_rdy) state_d = StRefill;
      end
      StRefill: begin
        if (bus.ret_valid && bus.ret_last) state_d = StResp;
      end
      StResp: begin
        bus.icache_data_ok = 1'b1;
        bus.icache_rdata   = resp_word_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
    bus.icache_addr_ok = accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      tag_q       <= '0;
      beat_q      <= '0;
      resp_word_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= bus.icache_index;
        word_q <= bus.icache_offset[3:2];
        tag_q  <= bus.icache_tag;
      end
      if (refill_beat) begin
        beat_q <= bus.ret_last ? 2'd0 : beat_q + 2'd1;
        if (beat_q == word_q) resp_word_q <= bus.ret_data;
        if (bus.ret_last) valid_q[idx_q] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (refill_beat) begin
      data_arr[idx_q][beat_q] <= bus.ret_data;
      if (bus.ret_last) tag_arr[idx_q] <= tag_q;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == StLookup) begin
      if (hit) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: model decides hit/miss, memory model refills,
// monitor compares every data_ok against the queued expectation.
module tb_icache_responder;
  logic clk = 1'b0;
  logic reset;
  icache_if bus ();
  always #5 clk = ~clk;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  icache_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr[$];
  bit          m_valid [256];
  logic [19:0] m_tag   [256];
  logic [19:0] tags    [3] = '{20'h0ABCD, 20'h05432, 20'hF0F0F};

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int dok_count = 0;
  int last_beat_cyc = 0;
  int last_resp_cyc = 0;
  int abort_beat = -1;
  bit miss_pending = 1'b0;
  bit stalled = 1'b0;
  bit release_abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: the fixed line of the cold-miss scenario, a tag/index pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [19:0] t, input logic [7:0] i,
                                           input logic [1:0] w);
    if (t == 20'h1FC00 && i == 8'h10) return 32'hA0 + {30'd0, w};
    return {t[15:0] ^ {i, i}, i, 6'h2A, w};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_checks++;
    $display("FAIL %s: got 0x%08h, required event did not occur as expected", name, got);
  endtask

  task automatic issue(input logic [7:0] idx, input logic [3:0] off, input logic [19:0] tag,
                       output int waited);
    bit held;
    bit ok;
    bit hit;
    held              = miss_pending;
    bus.icache_req    = 1'b1;
    bus.icache_index  = idx;
    bus.icache_offset = off;
    bus.icache_tag    = tag;
    waited = 0;
    ok     = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.icache_addr_ok) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      fail_now("accept_timeout", {24'd0, idx});
    end else begin
      check("accept_not_busy", {31'd0, miss_pending}, 32'd0);
      if (held) check("held_accept_cycle", 32'(cyc), 32'(last_resp_cyc + 1));
      hit = m_valid[idx] && (m_tag[idx] == tag);
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        exp_addr.push_back({tag, idx, 4'h0});
        miss_pending = 1'b1;
      end
      sb.push_back('{data: mem_word(tag, idx, off[3:2]), hit: hit, cyc: cyc});
    end
    @(posedge clk);
    #1;
    bus.icache_req = 1'b0;
  endtask

  task automatic expect_rd_addr(input logic [31:0] a);
    int n;
    n = 0;
    while (!bus.rd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rd_req) fail_now("rd_req_timeout", 32'd0);
    else check("rd_addr_directed", bus.rd_addr, a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || miss_pending) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n == 500) fail_now("drain_timeout", 32'(sb.size()));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every data_ok is matched against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.icache_data_ok) begin
          dok_count++;
          if (sb.size() == 0) begin
            fail_now("unexpected_data_ok", bus.icache_rdata);
          end else begin
            e = sb.pop_front();
            check("rdata", bus.icache_rdata, e.data);
            if (e.hit) begin
              check("hit_latency", 32'(cyc), 32'(e.cyc + 1));
            end else begin
              check("miss_latency", 32'(cyc), 32'(last_beat_cyc + 1));
              miss_pending  = 1'b0;
              last_resp_cyc = cyc;
            end
          end
        end else begin
          check("rdata_zero_when_idle", bus.icache_rdata, 32'd0);
        end
      end
    end
  end

  // Memory side: random accept delay and beat gaps, data taken from mem_word.
  initial begin : mem_side
    logic [31:0] a;
    bus.rd_rdy    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.rd_req && !reset) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.rd_rdy = 1'b1;
        a = bus.rd_addr;
        if (exp_addr.size() == 0) fail_now("unexpected_rd_req", a);
        else check("rd_addr", a, exp_addr.pop_front());
        @(posedge clk);
        #1;
        bus.rd_rdy = 1'b0;
        for (int w = 0; w < 4; w++) begin
          @(negedge clk);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          bus.ret_valid = 1'b1;
          bus.ret_data  = mem_word(a[31:12], a[11:4], 2'(w));
          bus.ret_last  = (w == 3);
          if (w == abort_beat) begin
            stalled = 1'b1;
            wait (release_abort);
          end
          if (w == 3) last_beat_cyc = cyc;
          @(posedge clk);
          #1;
          bus.ret_valid = 1'b0;
          bus.ret_last  = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int w;
    int n;
    int snap;
    logic [7:0]  idx;
    logic [3:0]  off;
    logic [19:0] tag;
    bus.icache_req    = 1'b0;
    bus.icache_index  = '0;
    bus.icache_offset = '0;
    bus.icache_tag    = '0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    reset = 1'b1;
    #1;
    bus.icache_req = 1'b1;
    #1;
    check("reset_addr_ok", {31'd0, bus.icache_addr_ok}, 32'd0);
    check("reset_data_ok", {31'd0, bus.icache_data_ok}, 32'd0);
    check("reset_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("reset_rdata", bus.icache_rdata, 32'd0);
    bus.icache_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then four back-to-back hits held behind the refill.
    issue(8'h10, 4'h8, 20'h1FC00, w);
    expect_rd_addr(32'h1FC00100);
    issue(8'h10, 4'h0, 20'h1FC00, w);
    issue(8'h10, 4'h4, 20'h1FC00, w);
    check("b2b_accept_4", 32'(w), 32'd0);
    issue(8'h10, 4'h8, 20'h1FC00, w);
    check("b2b_accept_8", 32'(w), 32'd0);
    issue(8'h10, 4'hC, 20'h1FC00, w);
    check("b2b_accept_c", 32'(w), 32'd0);
    drain();

    // Conflict on the same set, then the evicted tag misses again.
    issue(8'h10, 4'h0, 20'h00001, w);
    expect_rd_addr(32'h00001100);
    drain();
    issue(8'h10, 4'h4, 20'h1FC00, w);
    expect_rd_addr(32'h1FC00100);
    drain();
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_cnt", perf_hit_cnt, 32'd4);
    check("perf_miss_cnt", perf_miss_cnt, 32'd3);
`endif

    // Reset during beat 2 of a refill.
    abort_beat = 2;
    issue(8'h20, 4'h4, 20'h12345, w);
    n = 0;
    while (!stalled && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!stalled) fail_now("abort_beat_timeout", 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("midrefill_addr_ok", {31'd0, bus.icache_addr_ok}, 32'd0);
    check("midrefill_data_ok", {31'd0, bus.icache_data_ok}, 32'd0);
    check("midrefill_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("midrefill_rdata", bus.icache_rdata, 32'd0);
    sb.delete();
    exp_addr.delete();
    miss_pending = 1'b0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    abort_beat = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    release_abort = 1'b1;
    snap = dok_count;
    repeat (8) @(posedge clk);
    #1;
    check("no_data_ok_after_abort", 32'(dok_count), 32'(snap));
    check("idle_after_stray_beats", {31'd0, bus.rd_req}, 32'd0);
    issue(8'h20, 4'h4, 20'h12345, w);
    expect_rd_addr(32'h12345200);
    drain();

    // Randomized traffic over a few sets and competing tags.
    for (int k = 0; k < 250; k++) begin
      idx = 8'h40 + 8'($urandom_range(0, 3));
      tag = tags[$urandom_range(0, 2)];
      off = 4'($urandom_range(0, 15));
      issue(idx, off, tag, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
